concat_pair_aligner: RTL

Pairs two independent operand streams (A and B) into matched (a, b) words for the concat stage of the special-functions path. Each stream is buffered in its own small FIFO. A pair is released only when both FIFOs hold an entry, so producers with unequal timing or burstiness stay aligned element-for-element. Its output handshake drives the concat stage's `data_in_a`/`data_in_b`/`valid_in`/`ready_in` directly.

---
 rtl/concat_pair_aligner.sv | 86 ++++++++
 1 files changed

// File: rtl/concat_pair_aligner.sv
// concat_pair_aligner: pairs two buffered operand streams into aligned (a, b) words with a post-transfer hold
module concat_pair_aligner #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1,
  localparam int PTR_W = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  output logic [DATA_WIDTH-1:0] data_out_a,
  output logic [DATA_WIDTH-1:0] data_out_b,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic [LVL_W-1:0]      a_level,
  output logic [LVL_W-1:0]      b_level
);
  logic [DATA_WIDTH-1:0] a_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] b_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] a_rd_q, a_rd_d, a_wr_q, a_wr_d, b_rd_q, b_rd_d, b_wr_q, b_wr_d;
  logic [LVL_W-1:0] a_lvl_q, a_lvl_d, b_lvl_q, b_lvl_d;
  logic [DATA_WIDTH-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
  logic valid_q, valid_d, xfer_prev_q, xfer_prev_d;
  logic push_a, push_b, load, xfer;
  // Readies come from occupancy only; a load pops both heads and is held off for one cycle after a transfer
  always_comb begin
    a_ready = a_lvl_q != LVL_W'(FIFO_DEPTH);
    b_ready = b_lvl_q != LVL_W'(FIFO_DEPTH);
    push_a = a_valid && a_ready && !flush;
    push_b = b_valid && b_ready && !flush;
    xfer = valid_q && ready_out;
    load = (a_lvl_q != '0) && (b_lvl_q != '0) && !valid_q && !xfer_prev_q;
    a_wr_d = flush ? '0 : push_a ? a_wr_q + PTR_W'(1) : a_wr_q;
    b_wr_d = flush ? '0 : push_b ? b_wr_q + PTR_W'(1) : b_wr_q;
    a_rd_d = flush ? '0 : load ? a_rd_q + PTR_W'(1) : a_rd_q;
    b_rd_d = flush ? '0 : load ? b_rd_q + PTR_W'(1) : b_rd_q;
    a_lvl_d = flush ? '0 : a_lvl_q + LVL_W'(push_a) - LVL_W'(load);
    b_lvl_d = flush ? '0 : b_lvl_q + LVL_W'(push_b) - LVL_W'(load);
    out_a_d = (load && !flush) ? a_mem_q[a_rd_q] : out_a_q;
    out_b_d = (load && !flush) ? b_mem_q[b_rd_q] : out_b_q;
    valid_d = flush ? 1'b0 : load ? 1'b1 : xfer ? 1'b0 : valid_q;
    xfer_prev_d = xfer;
  end
  // Pointer, level and output-register state
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rd_q <= '0;
      a_wr_q <= '0;
      b_rd_q <= '0;
      b_wr_q <= '0;
      a_lvl_q <= '0;
      b_lvl_q <= '0;
      out_a_q <= '0;
      out_b_q <= '0;
      valid_q <= 1'b0;
      xfer_prev_q <= 1'b0;
    end else begin
      a_rd_q <= a_rd_d;
      a_wr_q <= a_wr_d;
      b_rd_q <= b_rd_d;
      b_wr_q <= b_wr_d;
      a_lvl_q <= a_lvl_d;
      b_lvl_q <= b_lvl_d;
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
      valid_q <= valid_d;
      xfer_prev_q <= xfer_prev_d;
    end
  end
  // FIFO storage; contents need no reset since levels gate every read
  always_ff @(posedge clk) begin
    if (push_a && !rst) a_mem_q[a_wr_q] <= a_data;
    if (push_b && !rst) b_mem_q[b_wr_q] <= b_data;
  end
  assign data_out_a = out_a_q;
  assign data_out_b = out_b_q;
  assign valid_out = valid_q;
  assign a_level = a_lvl_q;
  assign b_level = b_lvl_q;
endmodule
